apb4_reg_bridge: RTL and testbench
==================================

# apb4_reg_bridge

Parametrised APB4 slave that bridges an APB4 master onto the internal register-bus request/ready interface. It is the next generation of the basic APB4 slave. It adds per-byte write strobes (PSTRB to bit enables), address decode and alignment errors, honoured request stalls, registered responses, and an optional bus-timeout watchdog. It sits between the SoC APB fabric and one generated register block.

## Interface
Parameters:
- ADDR_WIDTH, 8: byte address width of paddr/bus_addr.
- DATA_WIDTH, 32: data width. Legal values are 8, 16, 32 or 64.
- MAX_ADDR, 2**ADDR_WIDTH-1: highest legal byte address. Accesses above it are errors.
- TIMEOUT_CYCLES, 16: watchdog limit in cycles, at least 2. Used only with the timeout macro.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- psel, penable, pwrite  in  1  APB4 control
- paddr  in  ADDR_WIDTH  APB address
- pwdata  in  DATA_WIDTH  write data
- pstrb  in  DATA_WIDTH/8  write byte strobes
- pprot  in  3  accepted and ignored
- pready, pslverr  out  1  APB response
- prdata  out  DATA_WIDTH  read data
- bus_req, bus_req_is_wr  out  1  internal request and direction
- bus_addr  out  ADDR_WIDTH  captured address
- bus_wr_data  out  DATA_WIDTH  captured write data
- bus_wr_biten  out  DATA_WIDTH  bit enables
- bus_ready, bus_err  in  1  internal completion and error
- bus_rd_data  in  DATA_WIDTH  internal read data
- bus_req_stall_wr, bus_req_stall_rd  in  1  holding off of write and read issue

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE:** psel&&!penable is a setup phase. On it, capture paddr, pwrite, pwdata and pstrb.
  - A decode error is paddr > MAX_ADDR, or nonzero paddr[log2(DATA_WIDTH/8)-1:0].
  - On a decode error, go to RESP with err=1 and rdata=0. No bus_req is issued.
  - Otherwise go to ISSUE.
- **ISSUE:** bus_req = 1 only while the stall for the captured direction is low. The FSM stays in ISSUE while that stall is high.
  - When bus_req=1 and bus_ready=1 in the same cycle, go to RESP.
  - When bus_req=1 and bus_ready=0, go to WAIT.
- **WAIT:** bus_req = 0. On bus_ready, register bus_err into pslverr. For reads, register bus_rd_data into prdata (writes give prdata 0). Then go to RESP.
- **RESP:** pready = psel&&penable. Return to IDLE in the cycle pready=1.
- **psel dropped:** if psel is low in ISSUE, WAIT or RESP, the internal transaction still completes, the response is discarded, and the FSM returns to IDLE.
- **Bus outputs:**
  - bus_addr, bus_wr_data and bus_req_is_wr are valid in ISSUE and WAIT, and 0 otherwise.
  - bus_wr_biten[8i+:8] = {8{pstrb[i]}} on writes, and all zero on reads.
  - A write with pstrb = 0 is still issued, with biten all zero.
- bus_ready and bus_err are ignored in IDLE and RESP, so a late ready after a timeout has no effect.

## Timing
- **Reset values:** FSM = IDLE. pready, pslverr, prdata, bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten and all capture registers are 0. Reset mid-transfer aborts without a response.
- **Normal access:** setup in cycle T, bus_req in T+1. With bus_ready in T+1, pready is in T+2 (one APB wait state). Each extra bus_ready cycle or stall cycle adds one wait state.
- **Decode error:** pready=1 and pslverr=1 at T+1 (zero wait states).
- **Signal kinds:** prdata and pslverr are registered. pready and bus_req are combinational from state and inputs.
- **Back-to-back transfers:** a new setup is accepted only in IDLE, i.e. the cycle after the pready cycle.

## Configuration
- Macro: APB4_BRIDGE_TIMEOUT_EN.
- **Defined:**
  - A counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT.
  - If the counter reaches TIMEOUT_CYCLES-1 with no bus_ready in that cycle, go to RESP with pslverr=1 and prdata=0.
  - bus_ready in that same cycle wins over the timeout.
- **Not defined:** no counter; the bridge waits for bus_ready indefinitely.

## Structure
- Package apb4_bridge_pkg contains:
  - the state enum typedef (IDLE, ISSUE, WAIT, RESP);
  - function strb_to_biten;
  - the legal-DATA_WIDTH check constant.
- Sub-module apb4_bridge_timeout holds the watchdog counter (clear, enable, expired) and is instantiated only under the macro.

## Test plan
- **Aligned write:** addr 0x04, pwdata 0xDEADBEEF, pstrb 0b0101, bus_ready in ISSUE → one bus_req with biten 0x00FF00FF, pready at T+2, pslverr 0.
- **Read with WAIT:** addr 0x08, bus_ready 3 cycles after bus_req with rd_data 0x12345678 and bus_err=1 → prdata 0x12345678, pslverr 1, pready at T+5.
- **Decode errors:** addr 0x06 (misaligned), and addr above MAX_ADDR=0x3F → no bus_req, pready and pslverr at T+1, prdata 0.
- **Stall:** bus_req_stall_wr high for 4 cycles on a write → bus_req held 0 for those cycles, then a single-cycle bus_req; no read-stall influence.
- **Timeout (macro on, TIMEOUT_CYCLES=16):** bus_ready never returns → pslverr at cycle T+17. A late bus_ready afterwards is ignored; the next transfer completes normally.
- **Abort cases:** rst asserted in WAIT → all outputs 0 next cycle, FSM IDLE. psel dropped in WAIT → no pready; IDLE after bus_ready.

Source files
------------

// File: rtl/apb4_bridge_pkg.sv
// Shared types and helpers for the APB4-to-register-bus bridge.
package apb4_bridge_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  // Bit (bytes-1) set for each supported data width: 1, 2, 4 and 8 bytes.
  localparam logic [7:0] LEGAL_DW_BYTES = 8'b1000_1011;

  function automatic logic legal_data_width(input int unsigned w);
    if ((w == 0) || (w > 64) || ((w % 8) != 0)) return 1'b0;
    return LEGAL_DW_BYTES[3'(w / 8 - 1)];
  endfunction

  function automatic logic [63:0] strb_to_biten(input logic [7:0] strb);
    logic [63:0] biten;
    biten = '0;
    for (int i = 0; i < 8; i++) biten[8*i +: 8] = {8{strb[i]}};
    return biten;
  endfunction

endpackage

// File: rtl/apb4_bridge_timeout.sv
// Bus watchdog: counts cycles of an outstanding request and flags expiry.
// Only built with APB4_BRIDGE_TIMEOUT_EN.
`ifdef APB4_BRIDGE_TIMEOUT_EN
module apb4_bridge_timeout
  import apb4_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturates at the limit so a long-stuck request keeps reporting expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (en_i && !expired_o)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/apb4_reg_bridge.sv
// APB4 slave bridging onto the register-bus request/ready interface.
// Optional bus watchdog enabled by defining APB4_BRIDGE_TIMEOUT_EN.
module apb4_reg_bridge
  import apb4_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_ADDR       = 2**ADDR_WIDTH - 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic                    pready,
  output logic                    pslverr,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    bus_req,
  output logic                    bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wr_data,
  output logic [DATA_WIDTH-1:0]   bus_wr_biten,
  input  logic                    bus_ready,
  input  logic                    bus_err,
  input  logic [DATA_WIDTH-1:0]   bus_rd_data,
  input  logic                    bus_req_stall_wr,
  input  logic                    bus_req_stall_rd
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);

  if (!legal_data_width(DATA_WIDTH) || (TIMEOUT_CYCLES < 2)) begin : g_bad_cfg
    $error("apb4_reg_bridge: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
  end

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    dec_err, stall, bus_active, timeout_hit;
  logic                    unused_pprot;

  assign unused_pprot = ^pprot;
  assign dec_err = (32'(paddr) > MAX_ADDR) || ((paddr & ALIGN_MASK) != '0);
  assign stall   = wr_q ? bus_req_stall_wr : bus_req_stall_rd;

`ifdef APB4_BRIDGE_TIMEOUT_EN
  apb4_bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == IDLE),
    .en_i     ((state_q == ISSUE) || (state_q == WAIT)),
    .expired_o(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    bus_req   = 1'b0;
    pready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d    = paddr;
          wr_d      = pwrite;
          wdata_d   = pwdata;
          strb_d    = pstrb;
          pslverr_d = dec_err;
          prdata_d  = '0;
          state_d   = dec_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        bus_req = !stall;
        // A completing handshake takes priority over a watchdog expiry.
        if (bus_req && bus_ready) begin
          state_d   = RESP;
          pslverr_d = bus_err;
          prdata_d  = wr_q ? '0 : bus_rd_data;
        end else if (timeout_hit) begin
          state_d   = RESP;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end else if (bus_req) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus_ready) begin
          state_d   = RESP;
          pslverr_d = bus_err;
          prdata_d  = wr_q ? '0 : bus_rd_data;
        end else if (timeout_hit) begin
          state_d   = RESP;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end
      end
      RESP: begin
        pready = psel && penable;
        // A master that dropped psel never sees this response.
        if (pready || !psel) begin
          state_d   = IDLE;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign bus_active    = (state_q == ISSUE) || (state_q == WAIT);
  assign bus_addr      = bus_active ? addr_q  : '0;
  assign bus_wr_data   = bus_active ? wdata_q : '0;
  assign bus_req_is_wr = bus_active && wr_q;
  assign bus_wr_biten  = (bus_active && wr_q) ? DATA_WIDTH'(strb_to_biten(8'(strb_q))) : '0;
  assign pslverr       = pslverr_q;
  assign prdata        = prdata_q;

endmodule

// File: tb/tb_apb4_reg_bridge.sv
// Randomized and directed bench for apb4_reg_bridge against a transaction-level timeline model.
module tb_apb4_reg_bridge;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXA = 63;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;
  logic          bus_req, bus_req_is_wr;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data, bus_wr_biten;
  logic          bus_ready, bus_err;
  logic [DW-1:0] bus_rd_data;
  logic          bus_req_stall_wr, bus_req_stall_rd;

  apb4_reg_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_ADDR(MAXA), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
    .bus_ready(bus_ready), .bus_err(bus_err), .bus_rd_data(bus_rd_data),
    .bus_req_stall_wr(bus_req_stall_wr), .bus_req_stall_rd(bus_req_stall_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Per-cycle expectations written by the stimulus, consumed by the compare process.
  logic          chk_en = 1'b0;
  logic          exp_pready, exp_req, exp_valid, exp_wr, exp_err, exp_all_zero;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_biten, exp_rdata;
  int            cur_cyc = -1;

  // Observations for the literal pins, owned by the compare process.
  int            obs_rcyc = -1;
  int            obs_req_n = 0;
  logic          obs_err = 1'b0;
  logic [DW-1:0] obs_rdata = '0;
  logic [DW-1:0] obs_biten = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] model_biten(input logic [SW-1:0] s);
    logic [DW-1:0] r;
    for (int i = 0; i < SW; i++) r[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pready", 32'(pready), 32'(exp_pready));
      chk("bus_req", 32'(bus_req), 32'(exp_req));
      chk("bus_req_is_wr", 32'(bus_req_is_wr), 32'(exp_valid & exp_wr));
      chk("bus_addr", 32'(bus_addr), exp_valid ? 32'(exp_addr) : 32'h0);
      chk("bus_wr_data", bus_wr_data, exp_valid ? exp_wdata : 32'h0);
      if (exp_valid || exp_all_zero)
        chk("bus_wr_biten", bus_wr_biten, exp_valid ? exp_biten : 32'h0);
      if (exp_pready || exp_all_zero) begin
        chk("pslverr", 32'(pslverr), exp_all_zero ? 32'h0 : 32'(exp_err));
        chk("prdata", prdata, exp_all_zero ? 32'h0 : exp_rdata);
      end
      if (cur_cyc == 0) begin
        obs_rcyc  = -1;
        obs_req_n = 0;
      end
      if (pready) begin
        obs_rcyc  = cur_cyc;
        obs_err   = pslverr;
        obs_rdata = prdata;
      end
      if (bus_req) begin
        obs_req_n++;
        obs_biten = bus_wr_biten;
      end
    end
  end

  task automatic set_exp_idle();
    exp_pready = 1'b0; exp_req = 1'b0; exp_valid = 1'b0; exp_wr = 1'b0;
    exp_err = 1'b0; exp_addr = '0; exp_wdata = '0; exp_biten = '0; exp_rdata = '0;
  endtask

  task automatic zero_cycle();
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0; bus_ready = 1'b0;
    cur_cyc = -1;
    set_exp_idle();
    exp_all_zero = 1'b1;
    chk_en = 1'b1;
    @(negedge clk); #1;
    exp_all_zero = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; cur_cyc = -1;
      paddr = AW'($urandom); pwrite = 1'($urandom); pwdata = $urandom;
      bus_ready = 1'($urandom); bus_err = 1'($urandom); bus_rd_data = $urandom;
      bus_req_stall_wr = 1'($urandom); bus_req_stall_rd = 1'($urandom);
      set_exp_idle();
    end
  endtask

  // One APB transfer. S = stall cycles, D = cycles from first bus_req to bus_ready.
  task automatic run_xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                          input logic [SW-1:0] st, input int S, input int D, input logic e,
                          input logic [DW-1:0] rd, input int drop_at, input bit no_ready,
                          input int abort_at);
    bit derr;
    int reqc, comp, lastv, R;
    logic merr;
    logic [DW-1:0] mrdata;
    derr = (int'(a) > MAXA) || (a[1:0] != 2'b00);
    if (derr) begin
      reqc = -1; comp = -1; lastv = 0; merr = 1'b1; mrdata = '0;
    end else begin
      reqc = S + 1;
      comp = no_ready ? 1000000 : reqc + D;
      lastv = comp; merr = e; mrdata = w ? '0 : rd;
`ifdef APB4_BRIDGE_TIMEOUT_EN
      if (comp > TO) begin
        lastv = TO; merr = 1'b1; mrdata = '0;
      end
`endif
    end
    R = lastv + 1;
    for (int c = 0; c <= R; c++) begin
      @(posedge clk); #1;
      cur_cyc = c;
      if (c == 0) begin
        psel = 1'b1; penable = 1'b0;
        paddr = a; pwrite = w; pwdata = wd; pstrb = st;
      end else begin
        if (drop_at > 0 && c >= drop_at) begin psel = 1'b0; penable = 1'b0; end
        else begin psel = 1'b1; penable = 1'b1; end
        paddr = AW'($urandom); pwrite = 1'($urandom); pwdata = $urandom; pstrb = SW'($urandom);
      end
      pprot = 3'($urandom);
      bus_req_stall_wr = w ? (c >= 1 && c <= S) : 1'($urandom);
      bus_req_stall_rd = !w ? (c >= 1 && c <= S) : 1'($urandom);
      if (c == comp) bus_ready = 1'b1;
      else if (c == R) bus_ready = no_ready ? 1'b1 : 1'($urandom);
      else if (c == 0) bus_ready = 1'($urandom);
      else bus_ready = 1'b0;
      bus_err     = (c == comp) ? e  : 1'($urandom);
      bus_rd_data = (c == comp) ? rd : $urandom;
      exp_valid  = !derr && c >= 1 && c <= lastv;
      exp_req    = exp_valid && (c == reqc);
      exp_pready = (c == R) && !(drop_at > 0 && c >= drop_at);
      exp_err = merr; exp_rdata = mrdata;
      exp_addr = a; exp_wr = w; exp_wdata = wd;
      exp_biten = w ? model_biten(st) : '0;
      if (abort_at > 0 && c == abort_at) begin
        rst = 1'b1;
        break;
      end
    end
    @(negedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    pstrb = '0; pprot = '0; bus_ready = 1'b0; bus_err = 1'b0; bus_rd_data = '0;
    bus_req_stall_wr = 1'b0; bus_req_stall_rd = 1'b0;
    set_exp_idle();
    exp_all_zero = 1'b0;
    repeat (2) @(posedge clk);
    zero_cycle();

    // Aligned write, ready in the issue cycle.
    run_xfer(8'h04, 1'b1, 32'hDEADBEEF, 4'b0101, 0, 0, 1'b0, 32'h0, 0, 1'b0, 0);
    chk("wr_pready_cycle", 32'(obs_rcyc), 32'd2);
    chk("wr_biten_lit", obs_biten, 32'h00FF00FF);
    chk("wr_req_count", 32'(obs_req_n), 32'd1);
    chk("wr_pslverr", 32'(obs_err), 32'd0);

    // Read held in WAIT for three cycles with a bus error.
    run_xfer(8'h08, 1'b0, 32'h0, 4'hF, 0, 3, 1'b1, 32'h12345678, 0, 1'b0, 0);
    chk("rd_pready_cycle", 32'(obs_rcyc), 32'd5);
    chk("rd_prdata", obs_rdata, 32'h12345678);
    chk("rd_pslverr", 32'(obs_err), 32'd1);

    // Decode errors: misaligned and out of range.
    run_xfer(8'h06, 1'b1, 32'hA5A5A5A5, 4'hF, 0, 0, 1'b0, 32'h0, 0, 1'b0, 0);
    chk("misalign_cycle", 32'(obs_rcyc), 32'd1);
    chk("misalign_err", 32'(obs_err), 32'd1);
    chk("misalign_noreq", 32'(obs_req_n), 32'd0);
    run_xfer(8'h40, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 32'hFFFFFFFF, 0, 1'b0, 0);
    chk("range_cycle", 32'(obs_rcyc), 32'd1);
    chk("range_prdata", obs_rdata, 32'h0);
    chk("range_noreq", 32'(obs_req_n), 32'd0);

    // Write stalled for four cycles.
    run_xfer(8'h0C, 1'b1, 32'h01020304, 4'b1000, 4, 0, 1'b0, 32'h0, 0, 1'b0, 0);
    chk("stall_req_count", 32'(obs_req_n), 32'd1);
    chk("stall_pready_cycle", 32'(obs_rcyc), 32'd6);

    // Write with no strobes is still issued.
    run_xfer(8'h10, 1'b1, 32'hCAFEF00D, 4'b0000, 0, 1, 1'b0, 32'h0, 0, 1'b0, 0);
    chk("nostrb_req_count", 32'(obs_req_n), 32'd1);
    chk("nostrb_biten", obs_biten, 32'h0);

    // psel dropped while waiting: no response, bridge back to IDLE.
    run_xfer(8'h14, 1'b0, 32'h0, 4'h0, 0, 3, 1'b0, 32'h55AA55AA, 2, 1'b0, 0);
    chk("drop_no_pready", 32'(obs_rcyc), 32'hFFFFFFFF);
    run_xfer(8'h18, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0BADF00D, 0, 1'b0, 0);
    chk("after_drop_prdata", obs_rdata, 32'h0BADF00D);

`ifdef APB4_BRIDGE_TIMEOUT_EN
    // Bus never answers; late ready in the response cycle must be ignored.
    run_xfer(8'h1C, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0, 0, 1'b1, 0);
    chk("to_pready_cycle", 32'(obs_rcyc), 32'd17);
    chk("to_pslverr", 32'(obs_err), 32'd1);
    chk("to_prdata", obs_rdata, 32'h0);
    run_xfer(8'h20, 1'b0, 32'h0, 4'h0, 0, 1, 1'b0, 32'h13572468, 0, 1'b0, 0);
    chk("after_to_prdata", obs_rdata, 32'h13572468);
`endif

    // Reset in WAIT aborts the transfer.
    run_xfer(8'h24, 1'b0, 32'h0, 4'h0, 0, 5, 1'b0, 32'h0, 0, 1'b0, 2);
    zero_cycle();
    run_xfer(8'h28, 1'b1, 32'h87654321, 4'b0011, 1, 0, 1'b0, 32'h0, 0, 1'b0, 0);
    chk("after_rst_biten", obs_biten, 32'h0000FFFF);
    chk("after_rst_cycle", 32'(obs_rcyc), 32'd3);

    for (int n = 0; n < 80; n++) begin
      logic [AW-1:0] a;
      int drop;
      a = AW'($urandom_range(0, 8'h47));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      drop = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      run_xfer(a, 1'($urandom), $urandom, SW'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 4), 1'($urandom), $urandom, drop, 1'b0, 0);
      idle_cycles($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
